// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter: FSM states, ALU select
// encodings and the flag vector layout.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    // ALU select encodings (must match the external ALU's s input)
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    // Flag vector layout {c,z,n,o}
    localparam int FLAG_W = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    // Assemble the four ALU flag bits into the response flag vector
    function automatic logic [FLAG_W-1:0] pack_flags(input logic c, input logic z,
                                                     input logic n, input logic o);
        logic [FLAG_W-1:0] f;
        f         = 4'b0000;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_N] = n;
        f[FLAG_O] = o;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// position above the pointer, wrapping, and returns the first hit.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Priority search from ptr+1 upward modulo N; first set bit wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IDX_W'((int'(i_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for a shared combinational ALU. One operation is
// accepted per grant, executed from registered operands for one cycle, and
// its result returned to the winner as a one-cycle response pulse.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 2,
    parameter int OP_W    = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_result,
    output logic [FLAG_W-1:0]         rsp_flags,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [OP_W-1:0]           alu_s,
    input  logic [DATA_W-1:0]         alu_y,
    input  logic                      alu_c,
    input  logic                      alu_z,
    input  logic                      alu_n,
    input  logic                      alu_o,
    output logic                      busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_e               r_state;
    state_e               w_next;
    logic [OP_W-1:0]      r_op;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [DATA_W-1:0]    r_result;
    logic [FLAG_W-1:0]    r_flags;
    logic [IDX_W-1:0]     r_grant;
    logic [IDX_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]   r_rsp_valid;

    logic [NUM_REQ-1:0]   w_grant;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE waits for a request, EXEC and RESP last one cycle each
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = EXEC;
                end else begin
                    w_next = IDLE;
                end
            end
            EXEC:    w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand latch on accept, result capture in EXEC, response pulse into RESP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_grant     <= '0;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_rsp_valid <= '0;
                    if (w_any) begin
                        r_op    <= req_op[w_idx*OP_W +: OP_W];
                        r_a     <= req_a[w_idx*DATA_W +: DATA_W];
                        r_b     <= req_b[w_idx*DATA_W +: DATA_W];
                        r_grant <= w_idx;
                        r_ptr   <= w_idx;
                    end
                end
                EXEC: begin
                    r_result    <= alu_y;
                    r_flags     <= pack_flags(alu_c, alu_z, alu_n, alu_o);
                    r_rsp_valid <= ONE_HOT0 << r_grant;
                end
                RESP:    r_rsp_valid <= '0;
                default: r_rsp_valid <= '0;
            endcase
        end
    end

    // Ready is Mealy in IDLE and forced low while reset is asserted
    assign req_ready  = (reset && (r_state == IDLE)) ? w_grant : '0;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_result = r_result;
    assign rsp_flags  = r_flags;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_s      = r_op;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural 2-bit ALU attached.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [7:0] req_op, req_a, req_b;
    logic [3:0] req_ready, rsp_valid;
    logic [1:0] rsp_result;
    logic [3:0] rsp_flags;
    logic [1:0] alu_a, alu_b, alu_s, alu_y;
    logic       alu_c, alu_z, alu_n, alu_o;
    logic       busy;
    logic [2:0] alu_t;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(4), .DATA_W(2), .OP_W(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .alu_a(alu_a), .alu_b(alu_b),
        .alu_s(alu_s), .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n),
        .alu_o(alu_o), .busy(busy)
    );

    // Behavioural ALU: c is carry (ADD) or borrow (SUB), o is signed overflow
    always_comb begin
        alu_t = 3'b000;
        alu_c = 1'b0;
        alu_o = 1'b0;
        case (alu_s)
            OP_ADD: begin
                alu_t = {1'b0, alu_a} + {1'b0, alu_b};
                alu_c = alu_t[2];
                alu_o = (alu_a[1] == alu_b[1]) && (alu_t[1] != alu_a[1]);
            end
            OP_SUB: begin
                alu_t = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c = alu_t[2];
                alu_o = (alu_a[1] != alu_b[1]) && (alu_t[1] != alu_a[1]);
            end
            OP_AND:  alu_t = {1'b0, alu_a & alu_b};
            default: alu_t = {1'b0, alu_a | alu_b};
        endcase
        alu_y = alu_t[1:0];
        alu_z = (alu_t[1:0] == 2'b00);
        alu_n = alu_t[1];
    end

    typedef struct packed { logic [3:0] oh; logic [1:0] op; logic [1:0] a; logic [1:0] b; } gnt_t;
    typedef struct packed { logic [3:0] oh; logic [1:0] res; logic [3:0] fl; } rsp_t;

    gnt_t gnt_q[$];
    rsp_t rsp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   hold[4];
    int   age = 0;
    gnt_t cur_g;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks grants, EXEC operands one cycle later and responses two cycles later
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_ready", 32'(req_ready), 32'h0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
            chk("rst_result", 32'(rsp_result), 32'h0);
            chk("rst_flags", 32'(rsp_flags), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
            chk("rst_alu_abs", 32'({alu_a, alu_b, alu_s}), 32'h0);
            age = 0;
        end else begin
            case (age)
                1: begin
                    chk("exec_alu_a", 32'(alu_a), 32'(cur_g.a));
                    chk("exec_alu_b", 32'(alu_b), 32'(cur_g.b));
                    chk("exec_alu_s", 32'(alu_s), 32'(cur_g.op));
                    chk("exec_busy", 32'(busy), 32'h1);
                    chk("exec_ready", 32'(req_ready), 32'h0);
                    chk("exec_rsp_valid", 32'(rsp_valid), 32'h0);
                    age = 2;
                end
                2: begin
                    chk("resp_busy", 32'(busy), 32'h1);
                    chk("resp_ready", 32'(req_ready), 32'h0);
                    if (rsp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL resp_queue: response slot with no expected entry, rsp_valid=%0h", rsp_valid);
                    end else begin
                        rsp_t r;
                        r = rsp_q.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(r.oh));
                        chk("rsp_result", 32'(rsp_result), 32'(r.res));
                        chk("rsp_flags", 32'(rsp_flags), 32'(r.fl));
                    end
                    age = 0;
                end
                default: begin
                    if (rsp_valid != 4'b0000) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 32'h0);
                    end
                    if (req_ready != 4'b0000) begin
                        if (gnt_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL grant_queue: unexpected req_ready got %0h expected 0", req_ready);
                        end else begin
                            cur_g = gnt_q.pop_front();
                            chk("req_ready", 32'(req_ready), 32'(cur_g.oh));
                        end
                        age = 1;
                    end else begin
                        chk("idle_busy", 32'(busy), 32'h0);
                    end
                end
            endcase
        end
    end

    task automatic push_gnt(input int i, input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        gnt_t g;
        g.oh = 4'(1 << i); g.op = op; g.a = a; g.b = b;
        gnt_q.push_back(g);
    endtask

    task automatic push_rsp(input int i, input logic [1:0] res, input logic [3:0] fl);
        rsp_t r;
        r.oh = 4'(1 << i); r.res = res; r.fl = fl;
        rsp_q.push_back(r);
    endtask

    task automatic set_req(input int i, input logic [1:0] op, input logic [1:0] a,
                           input logic [1:0] b, input int h);
        req_op[i*2 +: 2] = op;
        req_a[i*2 +: 2]  = a;
        req_b[i*2 +: 2]  = b;
        req_valid[i]     = 1'b1;
        hold[i]          = h;
    endtask

    // One clock: note accepts at the negedge, retire held requests just after the edge
    task automatic cycle();
        logic [3:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i] && hold[i] > 0) begin
                hold[i]--;
                if (hold[i] == 0) req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic bit any_hold();
        return (hold[0] != 0) || (hold[1] != 0) || (hold[2] != 0) || (hold[3] != 0);
    endfunction

    task automatic run(input int limit);
        int n;
        n = 0;
        while (any_hold() && n < limit) begin cycle(); n++; end
        chk("run_timeout", 32'(any_hold()), 32'h0);
        n = 0;
        while ((gnt_q.size() != 0 || rsp_q.size() != 0 || age != 0) && n < 20) begin cycle(); n++; end
        chk("drain_timeout", 32'(gnt_q.size() + rsp_q.size()), 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset = 1'b0;
        req_valid = 4'b0000; req_op = 8'h00; req_a = 8'h00; req_b = 8'h00;
        for (int i = 0; i < 4; i++) hold[i] = 0;

        // Reset with random requests
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_valid = 4'($urandom); req_op = 8'($urandom);
            req_a = 8'($urandom); req_b = 8'($urandom);
        end
        @(posedge clk); #1;
        req_valid = 4'b0000;
        reset = 1'b1;

        // Single op: 3+1 wraps to 0 with carry and zero
        push_gnt(0, OP_ADD, 2'd3, 2'd1); push_rsp(0, 2'd0, 4'b1100);
        set_req(0, OP_ADD, 2'd3, 2'd1, 1);
        run(20);

        // Fairness from reset: 0,1,2,3,0
        do_reset();
        push_gnt(0, OP_SUB, 2'd1, 2'd2); push_rsp(0, 2'd3, 4'b1011);
        push_gnt(1, OP_AND, 2'd3, 2'd2); push_rsp(1, 2'd2, 4'b0010);
        push_gnt(2, OP_OR,  2'd1, 2'd0); push_rsp(2, 2'd1, 4'b0000);
        push_gnt(3, OP_ADD, 2'd1, 2'd1); push_rsp(3, 2'd2, 4'b0011);
        push_gnt(0, OP_SUB, 2'd1, 2'd2); push_rsp(0, 2'd3, 4'b1011);
        set_req(0, OP_SUB, 2'd1, 2'd2, 2);
        set_req(1, OP_AND, 2'd3, 2'd2, 1);
        set_req(2, OP_OR,  2'd1, 2'd0, 1);
        set_req(3, OP_ADD, 2'd1, 2'd1, 1);
        run(40);

        // Lone requester 1 wins from ptr=0, leaving ptr=1
        push_gnt(1, OP_SUB, 2'd2, 2'd1); push_rsp(1, 2'd1, 4'b0001);
        set_req(1, OP_SUB, 2'd2, 2'd1, 1);
        run(20);

        // Sparse wrap: requesters 1 and 3 with ptr=1 -> 3 then 1
        push_gnt(3, OP_AND, 2'd2, 2'd3); push_rsp(3, 2'd2, 4'b0010);
        push_gnt(1, OP_SUB, 2'd2, 2'd1); push_rsp(1, 2'd1, 4'b0001);
        set_req(1, OP_SUB, 2'd2, 2'd1, 1);
        set_req(3, OP_AND, 2'd2, 2'd3, 1);
        run(20);

        // Reset during EXEC drops the operation
        push_gnt(1, OP_ADD, 2'd1, 2'd1);
        set_req(1, OP_ADD, 2'd1, 2'd1, 1);
        n = 0;
        while (hold[1] != 0 && n < 10) begin cycle(); n++; end
        chk("exec_accept_timeout", 32'(hold[1]), 32'h0);
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        push_gnt(0, OP_OR,  2'd2, 2'd1); push_rsp(0, 2'd3, 4'b0010);
        push_gnt(2, OP_ADD, 2'd2, 2'd2); push_rsp(2, 2'd0, 4'b1101);
        set_req(0, OP_OR,  2'd2, 2'd1, 1);
        set_req(2, OP_ADD, 2'd2, 2'd2, 1);
        run(20);

        // Withdrawal: requester 2 raises valid in EXEC and drops it in RESP
        push_gnt(0, OP_AND, 2'd1, 2'd1); push_rsp(0, 2'd1, 4'b0000);
        set_req(0, OP_AND, 2'd1, 2'd1, 1);
        cycle();
        req_op[5:4] = OP_ADD; req_a[5:4] = 2'd3; req_b[5:4] = 2'd3;
        req_valid[2] = 1'b1;
        cycle();
        req_valid[2] = 1'b0;
        repeat (4) cycle();
        chk("withdraw_busy", 32'(busy), 32'h0);
        chk("final_gnt_q", 32'(gnt_q.size()), 32'h0);
        chk("final_rsp_q", 32'(rsp_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 2-bit ALU among NUM_REQ requesters using round-robin arbitration.
- Accepts one operation per grant through a valid/ready handshake, and holds the operands in internal registers.
- Drives the ALU from those registers for one cycle, captures the result and flags, then returns them to the winner with a one-cycle response pulse.
- Sits between the user-input FSMs and the ALU instance; the ALU stays outside this block.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_W, 2, operand/result width; must match the ALU
OP_W, 2, operation select width; must match the ALU select

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_valid  in  NUM_REQ  per-requester request valid
req_op  in  NUM_REQ*OP_W  requester i at [i*OP_W +: OP_W]
req_a  in  NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
req_b  in  NUM_REQ*DATA_W  operand B, same packing
req_ready  out  NUM_REQ  one-hot accept, combinational in IDLE
rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse
rsp_result  out  DATA_W  last captured ALU result
rsp_flags  out  4  last captured {c,z,n,o}
alu_a  out  DATA_W  to ALU a
alu_b  out  DATA_W  to ALU b
alu_s  out  OP_W  to ALU s
alu_y  in  DATA_W  from ALU y
alu_c, alu_z, alu_n, alu_o  in  1 each  ALU flags
busy  out  1  high in EXEC and RESP

Behaviour:
- Reset (reset=0, async): state=IDLE; operand/op regs=0 so alu_a/alu_b/alu_s=0; rsp_result=0, rsp_flags=0, rsp_valid=0; grant index=0; rr pointer=NUM_REQ-1, so requester 0 has top priority first.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit searching from ptr+1 upward, wrapping modulo NUM_REQ.
  - req_ready[winner]=1 (Mealy, same cycle); all other ready bits are 0.
  - On the clock edge: latch req_op/a/b of the winner, store the grant index, set ptr=winner, go to EXEC.
  - If no req_valid is high: stay in IDLE with req_ready=0.
- EXEC:
  - alu_a/alu_b/alu_s come from the latched registers; the ALU output settles within the cycle.
  - On the edge: capture alu_y into rsp_result and {alu_c,alu_z,alu_n,alu_o} into rsp_flags, go to RESP.
- RESP: rsp_valid[grant]=1 for exactly this cycle; next state is IDLE.
- Timing: accept at cycle T, rsp_valid at T+2, next accept earliest at T+3, giving a throughput of one op per 3 cycles.
- rsp_result/rsp_flags hold their value until the next EXEC capture; they are valid whenever rsp_valid is high.
- Handshake:
  - Transfer happens only when req_valid[i] & req_ready[i].
  - A requester may drop valid before it is accepted with no effect.
  - Requests arriving during EXEC/RESP wait; req_ready=0 outside IDLE.
- A single requester asserting continuously is served every 3 cycles. A lone requester always wins regardless of ptr.
- Arithmetic is done entirely in the ALU; the block performs no width extension and no arithmetic of its own.
- Reset asserted mid-EXEC/RESP: the operation is dropped, no rsp_valid is issued, and all state returns to reset values immediately.
- alu_* outputs are registered values only, so they are glitch-free and independent of req_* in EXEC.

Decomposition:
- Package alu_arb_pkg:
  - state enum {IDLE, EXEC, RESP}
  - op constants matching the ALU select: OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11
  - FLAG_W=4 and flag bit indices C=3, Z=2, N=1, O=0
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any.

Test Plan:
- Reset: hold reset=0 with random req_* -> req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0, busy=0, alu_a/b/s=0.
- Single op: requester 0 requests ADD with a=3, b=1 at cycle T -> req_ready=0001 at T; alu_a=3, alu_b=1 at T+1; rsp_valid=0001 at T+2 with rsp_result=0 and flags c=1, z=1, n=0, o=0.
- Fairness: all 4 requesters hold valid continuously -> grants go 0,1,2,3,0, one every 3 cycles, each rsp_valid bit matching its grant.
- Sparse wrap: ptr=1, requesters 1 and 3 valid -> grant 3 first, then 1; requester 3 AND a=2, b=3 -> rsp_result=2.
- Reset in EXEC: assert reset during EXEC -> no rsp_valid; after release with requesters 0 and 2 valid -> requester 0 is granted first.
- Withdrawal: requester 2 raises valid during EXEC, then drops it before RESP ends -> requester 2 never gets req_ready or rsp_valid, and the block returns to idle.
